// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, default bit timing and frame constants.
package uart_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 217;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction
endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte-write handshake and serial/status signals of the buffered UART transmitter.
interface uart_tx_buffered_if
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
);
  logic                           i_TX_DV;
  logic [DATA_BITS-1:0]           i_TX_Byte;
  logic                           o_TX_Ready;
  logic                           o_TX_Serial;
  logic                           o_TX_Active;
  logic                           o_TX_Done;
  logic [$clog2(FIFO_DEPTH):0]    o_FIFO_Count;

  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done, o_FIFO_Count
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Ready, o_TX_Serial, o_TX_Active, o_TX_Done, o_FIFO_Count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular-buffer FIFO with registered full flag; pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && (count_q != '0);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter with back-to-back frames.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic              i_Clock,
  input  logic              i_Rst_L,
  uart_tx_buffered_if.slave tx
);
  localparam int             CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int             CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("CLKS_PER_BIT must be at least 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("PARITY_ODD must be 0 or 1");
  end

  tx_state_e            state_q;
  logic [CNT_W-1:0]     clk_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q, fifo_data;
  logic                 serial_q, active_q, done_q;
  logic                 fifo_empty, fifo_full, bit_end, pop, line_d;
  logic [CW-1:0]        fifo_count;

  assign bit_end = (clk_cnt_q == CNT_LAST);
  assign pop     = !fifo_empty && ((state_q == ST_IDLE) || (state_q == ST_STOP && bit_end));

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_Clock),
    .rst_ni  (i_Rst_L),
    .push_i  (tx.i_TX_DV),
    .pop_i   (pop),
    .data_i  (tx.i_TX_Byte),
    .data_o  (fifo_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    line_d = 1'b1;
    case (state_q)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_d = parity_bit(shift_q, PARITY_ODD != 0);
`endif
      default:   line_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (pop) shift_q <= fifo_data;
  end

  // Outputs are registered from the current state, so the line trails the FSM by one clock.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      serial_q  <= line_d;
      active_q  <= (state_q != ST_IDLE);
      done_q    <= (state_q == ST_STOP) && bit_end;
      clk_cnt_q <= (state_q == ST_IDLE || bit_end) ? '0 : clk_cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          bit_idx_q <= '0;
          if (pop) state_q <= ST_START;
        end
        ST_START: if (bit_end) state_q <= ST_DATA;
        ST_DATA: if (bit_end) begin
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
            state_q   <= ST_PARITY;
`else
            state_q   <= ST_STOP;
`endif
          end else begin
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (bit_end) state_q <= ST_STOP;
`endif
        ST_STOP: if (bit_end) state_q <= pop ? ST_START : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx.o_TX_Serial  = serial_q;
  assign tx.o_TX_Active  = active_q;
  assign tx.o_TX_Done    = done_q;
  assign tx.o_TX_Ready   = !fifo_full;
  assign tx.o_FIFO_Count = fifo_count;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-level reference model plus directed literal checks.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int P_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) tif ();

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(P_ODD)) dut (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .tx      (tif.slave)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int act_total = 0;
  int done_times[$];

  // frame-level model
  logic [7:0] m_q[$];
  bit         m_busy = 1'b0;
  int         m_t = 0;
  logic       m_bits[0:10];
  logic       m_line = 1'b1, m_act = 1'b0, m_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
  endtask

  task automatic load_frame(input logic [7:0] b);
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    m_bits[9] = (^b) ^ P_ODD[0];
`endif
    m_bits[NB-1] = 1'b1;
    m_t = 0;
    m_busy = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    bit pop_ok, push;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete();
      m_busy = 1'b0; m_t = 0;
      m_line = 1'b1; m_act = 1'b0; m_done = 1'b0;
    end else begin
      m_line = m_busy ? m_bits[m_t / CPB] : 1'b1;
      m_act  = m_busy;
      m_done = m_busy && (m_t == FRAME - 1);
      pop_ok = !m_busy || (m_t == FRAME - 1);
      push   = tif.i_TX_DV && (m_q.size() < DEPTH);
      if (m_busy) begin
        m_t++;
        if (m_t == FRAME) m_busy = 1'b0;
      end
      if (pop_ok && m_q.size() > 0) load_frame(m_q.pop_front());
      if (push) m_q.push_back(tif.i_TX_Byte);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("serial", tif.o_TX_Serial, m_line);
      chk("active", tif.o_TX_Active, m_act);
      chk("done",   tif.o_TX_Done,   m_done);
      chk("count",  tif.o_FIFO_Count, m_q.size());
      chk("ready",  tif.o_TX_Ready,  m_q.size() < DEPTH);
      if (tif.o_TX_Done) done_times.push_back(cyc);
      if (tif.o_TX_Active) act_total++;
    end
  end

  task automatic send(input logic [7:0] b);
    tif.i_TX_DV = 1'b1;
    tif.i_TX_Byte = b;
    @(posedge clk);
    #1;
    tif.i_TX_DV = 1'b0;
    tif.i_TX_Byte = ~b;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!m_busy && m_q.size() == 0 && !tif.o_TX_Active) ok = 1'b1;
    end
    chk("idle_timeout", ok, 1'b1);
  endtask

  initial begin
    logic s[0:63];
`ifdef UART_TX_PARITY_EN
    logic [10:0] exp_a5 = 11'b1_0_10100101_0;
`else
    logic [9:0]  exp_a5 = 10'b1_10100101_0;
`endif
    int dn, dpos, an, d0, a0, lows;

    tif.i_TX_DV = 1'b0;
    tif.i_TX_Byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial", tif.o_TX_Serial, 1'b1);
    chk("rst_ready",  tif.o_TX_Ready,  1'b1);
    chk("rst_active", tif.o_TX_Active, 1'b0);
    chk("rst_done",   tif.o_TX_Done,   1'b0);
    chk("rst_count",  tif.o_FIFO_Count, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single byte 0xA5
    dn = 0; dpos = -1; an = 0;
    send(8'hA5);
    for (int k = 0; k < 56; k++) begin
      @(negedge clk);
      s[k] = tif.o_TX_Serial;
      if (tif.o_TX_Done) begin dn++; dpos = k; end
      if (tif.o_TX_Active) an++;
    end
    chk("a5_pre_start", s[1], 1'b1);
    for (int b = 0; b < NB; b++) chk("a5_bit", s[2 + 4*b + (b % 4)], exp_a5[b]);
    chk("a5_done_count", dn, 1);
`ifdef UART_TX_PARITY_EN
    chk("a5_done_pos", dpos, 45);
    chk("a5_active_len", an, 44);
`else
    chk("a5_done_pos", dpos, 41);
    chk("a5_active_len", an, 40);
`endif
    wait_idle();

    // burst of three contiguous frames
    d0 = done_times.size(); a0 = act_total;
    send(8'h00); send(8'hFF); send(8'h55);
    wait_idle();
    chk("burst_done_count", done_times.size() - d0, 3);
    if (done_times.size() - d0 == 3) begin
      chk("burst_gap1", done_times[d0+1] - done_times[d0], FRAME);
      chk("burst_gap2", done_times[d0+2] - done_times[d0+1], FRAME);
    end
    chk("burst_active_len", act_total - a0, 3 * FRAME);

    // six writes while idle: four queue, sixth dropped
    d0 = done_times.size();
    for (int i = 0; i < 6; i++) begin
      tif.i_TX_DV = 1'b1;
      tif.i_TX_Byte = 8'(8'h30 + i);
      @(posedge clk);
      #1;
      if (i == 4) begin
        chk("full_count", tif.o_FIFO_Count, 4);
        chk("full_ready", tif.o_TX_Ready, 1'b0);
      end
    end
    tif.i_TX_DV = 1'b0;
    wait_idle();
    chk("full_frames", done_times.size() - d0, 5);

    // push on the edge that pops at the end of a stop bit
    send(8'h11); send(8'h22); send(8'h33);
    chk("pp_pre_count", tif.o_FIFO_Count, 2);
    repeat (38) @(posedge clk);
    #1;
    tif.i_TX_DV = 1'b1;
    tif.i_TX_Byte = 8'h44;
    @(posedge clk);
    #1;
    tif.i_TX_DV = 1'b0;
    chk("pp_count", tif.o_FIFO_Count, 2);
    chk("pp_ready", tif.o_TX_Ready, 1'b1);
    chk("pp_done",  tif.o_TX_Done, 1'b1);
    wait_idle();

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones, so even parity gives a 1
    send(8'h07);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      s[k] = tif.o_TX_Serial;
    end
    chk("par07_bit", s[39], 1'b1);
    chk("par07_stop", s[43], 1'b1);
    wait_idle();
`endif

    // reset during data bit 3 of 0x0F with two bytes queued
    send(8'h0F); send(8'hA1); send(8'hB2);
    repeat (16) @(posedge clk);
    #2;
    chk("mid_active", tif.o_TX_Active, 1'b1);
    chk("mid_count",  tif.o_FIFO_Count, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_serial", tif.o_TX_Serial, 1'b1);
    chk("arst_count",  tif.o_FIFO_Count, 0);
    chk("arst_active", tif.o_TX_Active, 1'b0);
    #3;
    rst_n = 1'b1;
    an = 0; lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tif.o_TX_Active) an++;
      if (!tif.o_TX_Serial) lows++;
    end
    chk("post_rst_active", an, 0);
    chk("post_rst_lows", lows, 0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      tif.i_TX_DV = ($urandom_range(0, 15) < ((i / 300) % 2 == 0 ? 1 : 8));
      tif.i_TX_Byte = 8'($urandom);
      @(posedge clk);
      #1;
    end
    tif.i_TX_DV = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Serial UART transmitter for the host link: 8 data bits, 1 start bit, 1 stop bit, LSB first, no parity by default.
- Bytes are written through a valid/ready port into a small internal FIFO so the CPU-side logic can burst several bytes.
- Frames go out back-to-back with no idle gap.
- Pairs with the existing UART receiver on the same CLKS_PER_BIT setting.

Parameters:
- CLKS_PER_BIT, 217: clocks per serial bit (clock frequency / baud); legal range ≥2.
- FIFO_DEPTH, 4: FIFO entries; power of two, ≥2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; used only with UART_TX_PARITY_EN.

Ports:
- i_Clock  in  1  system clock.
- i_Rst_L  in  1  reset: asynchronous assert, active-low.
- i_TX_DV  in  1  write strobe; accepted on a rising edge when o_TX_Ready=1.
- i_TX_Byte  in  8  byte to send; sampled together with i_TX_DV.
- o_TX_Ready  out  1  FIFO not full, registered.
- o_TX_Serial  out  1  serial line, idle high, registered.
- o_TX_Active  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- o_TX_Done  out  1  one-clock pulse in the final cycle of each stop bit.
- o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  bytes held in the FIFO (excludes the byte in the shift register).

Behaviour:
- Reset (i_Rst_L=0, asynchronous):
  - o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0, o_FIFO_Count=0.
  - FIFO pointers cleared; state=IDLE.
  - Reset mid-frame: the line returns high immediately and queued bytes are discarded.
- Write handshake:
  - i_TX_DV=1 and o_TX_Ready=1 at an edge → byte pushed.
  - i_TX_DV=1 while o_TX_Ready=0 → byte dropped, no state change.
  - Push and pop on the same edge → count unchanged.
  - o_TX_Ready=0 exactly when count==FIFO_DEPTH.
- FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH. Count width carries the full-depth value.
- Bit-time counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, then clears. Every bit is held exactly CLKS_PER_BIT clocks.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the feature is enabled).
  - IDLE: line=1. If the FIFO is non-empty, pop into the shift register, clear the counters, go to START.
    - Latency: a write into an empty, idle block gives o_TX_Serial=0 starting two clocks after the accepting edge.
  - START: line=0 for CLKS_PER_BIT clocks → DATA.
  - DATA: line=shift[bit_index], bit 0 first. Bit index 0..7; after bit 7's last clock → STOP.
  - STOP: line=1 for CLKS_PER_BIT clocks. o_TX_Done=1 on the last clock.
    - At the end of STOP, if the FIFO is non-empty: pop and go straight to START (no gap).
    - Otherwise go to IDLE.
- Frame timing: 10*CLKS_PER_BIT clocks per frame; consecutive frames are contiguous.
- o_TX_Active falls in the first IDLE cycle.
- i_TX_Byte changes after acceptance never affect a queued or in-flight byte.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, held CLKS_PER_BIT clocks.
  - Parity bit = ^byte XOR PARITY_ODD.
  - Frame = 11*CLKS_PER_BIT clocks.
- Undefined: no PARITY state or logic; PARITY_ODD is ignored; frame = 10 bits.

Decomposition:
- Package uart_pkg:
  - FSM state encodings (3 bits: IDLE, START, DATA, PARITY, STOP).
  - Default CLKS_PER_BIT constant 217, shared with the receiver.
  - DATA_BITS=8.
- Sub-module uart_tx_fifo:
  - Synchronous FIFO with push/pop/count/full/empty, parameterised by width and depth.
  - Same clock and async active-low reset.
  - Instantiated once.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: write 0xA5 → o_TX_Serial low 2 clocks after the write. Line then reads bits 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks. o_TX_Done pulses once; 40 clocks total.
- Burst: write 0x00, 0xFF, 0x55 on consecutive clocks → three contiguous 40-clock frames with no idle high between the stop and the next start. Three o_TX_Done pulses, 40 clocks apart.
- Full/drop: write 6 bytes on consecutive clocks while idle. The first is popped at once, 4 are queued, o_TX_Ready drops, and the 6th is dropped. Exactly 5 frames are output.
- Simultaneous push/pop: with count=2, write on the STOP-final edge → count stays 2, o_TX_Ready stays 1.
- Reset mid-frame: assert i_Rst_L=0 during DATA bit 3 of 0x0F with 2 bytes queued → line=1 asynchronously, count=0. After release, the line stays idle high and no frames are sent.
- UART_TX_PARITY_EN, PARITY_ODD=0: send 0x07 → parity bit 1 after bit 7; 44-clock frame. With PARITY_ODD=1 the parity bit is 0.
